// File: rtl/tm1638_key_events.sv
// TM1638 key debouncer and event queue.
// Debounced levels, press/release/repeat events through a 4-deep FIFO.
module tm1638_key_events #(
  parameter int TICK_DIV     = 1000,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic [7:0] push_buttons,
  output logic [7:0] keys_state,
  output logic       event_valid,
  output logic [4:0] event_code,
  input  logic       event_ready,
  output logic       overflow
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = (RMAX < 2) ? 1 : $clog2(RMAX);

  localparam logic [PW-1:0] TMAX    = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CMAX    = CW'(DEBOUNCE - 1);
  localparam logic [RW-1:0] DLY_M1  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_M1 = RW'(REPEAT_RATE - 1);

  logic [PW-1:0]         presc_q, presc_d;
  logic [7:0][CW-1:0]    cnt_q, cnt_d;
  logic [7:0]            keys_q, keys_d;
  logic [7:0]            press_req, rel_req;
  logic                  tick;

  logic [2:0]            rep_key_q, rep_key_d;
  logic [RW-1:0]         rep_cnt_q, rep_cnt_d;
  logic                  armed_q, armed_d;
  logic                  phase_q, phase_d;
  logic                  rep_req;

  logic [7:0]            press_q, press_d;
  logic [7:0]            rel_q, rel_d;
  logic                  rep_pend_q, rep_pend_d;
  logic [2:0]            rep_pkey_q, rep_pkey_d;
  logic                  ovf_q, ovf_d;

  logic [3:0][4:0]       mem_q, mem_d;
  logic [1:0]            wr_q, wr_d;
  logic [1:0]            rd_q, rd_d;
  logic [2:0]            fcnt_q, fcnt_d;

  logic                  found;
  logic [4:0]            sel_code;
  logic [7:0]            clr_press, clr_rel;
  logic                  clr_rep;
  logic                  do_push, pop, full;

  assign tick        = (presc_q == TMAX);
  assign keys_state  = keys_q;
  assign event_valid = (fcnt_q != 3'd0);
  assign event_code  = event_valid ? mem_q[rd_q] : 5'd0;
  assign overflow    = ovf_q;
  assign pop         = event_valid & event_ready;
  assign full        = (fcnt_q == 3'd4);

  // Prescaler and per-key debounce counters
  always_comb begin
    presc_d   = tick ? '0 : presc_q + PW'(1);
    keys_d    = keys_q;
    cnt_d     = cnt_q;
    press_req = '0;
    rel_req   = '0;
    if (tick) begin
      for (int i = 0; i < 8; i++) begin
        if (push_buttons[i] == keys_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CMAX) begin
          keys_d[i]    = ~keys_q[i];
          cnt_d[i]     = '0;
          press_req[i] = ~keys_q[i];
          rel_req[i]   = keys_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Auto-repeat tracker for the most recently pressed key
  always_comb begin
    rep_key_d = rep_key_q;
    rep_cnt_d = rep_cnt_q;
    armed_d   = armed_q;
    phase_d   = phase_q;
    rep_req   = 1'b0;
    if (tick) begin
      if (armed_q && keys_q[rep_key_q]) begin
        if (rep_cnt_q == (phase_q ? RATE_M1 : DLY_M1)) begin
          rep_req   = 1'b1;
          rep_cnt_d = '0;
          phase_d   = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
      end
      if (rel_req[rep_key_q]) armed_d = 1'b0;
      if (|press_req) begin
        for (int i = 0; i < 8; i++) begin
          if (press_req[i]) rep_key_d = 3'(i);
        end
        armed_d   = 1'b1;
        rep_cnt_d = '0;
        phase_d   = 1'b0;
      end
    end
  end

  // Pending-request arbitration into the FIFO
  always_comb begin
    found     = 1'b0;
    sel_code  = 5'd0;
    clr_press = '0;
    clr_rel   = '0;
    clr_rep   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && press_q[i]) begin
        found        = 1'b1;
        clr_press[i] = 1'b1;
        sel_code     = {2'b01, 3'(i)};
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (!found && rel_q[i]) begin
        found      = 1'b1;
        clr_rel[i] = 1'b1;
        sel_code   = {2'b10, 3'(i)};
      end
    end
    if (!found && rep_pend_q) begin
      found    = 1'b1;
      clr_rep  = 1'b1;
      sel_code = {2'b11, rep_pkey_q};
    end
    do_push = found & (~full | pop);
    if (!do_push) begin
      clr_press = '0;
      clr_rel   = '0;
      clr_rep   = 1'b0;
    end
  end

  // Pending registers, overflow flag and FIFO bookkeeping
  always_comb begin
    press_d    = (press_q & ~clr_press) | press_req;
    rel_d      = (rel_q & ~clr_rel) | rel_req;
    rep_pend_d = (rep_pend_q & ~clr_rep) | rep_req;
    rep_pkey_d = rep_pkey_q;
    if (rep_req && !(rep_pend_q && !clr_rep)) rep_pkey_d = rep_key_q;
    ovf_d = ovf_q
          | (|(press_q & ~clr_press & press_req))
          | (|(rel_q & ~clr_rel & rel_req))
          | (rep_pend_q & ~clr_rep & rep_req);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = sel_code;
    wr_d   = wr_q + 2'(do_push);
    rd_d   = rd_q + 2'(pop);
    fcnt_d = fcnt_q + 3'(do_push) - 3'(pop);
  end

  // State registers with synchronous reset
  always_ff @(posedge mclk) begin
    if (rst) begin
      presc_q    <= '0;
      cnt_q      <= '0;
      keys_q     <= '0;
      rep_key_q  <= '0;
      rep_cnt_q  <= '0;
      armed_q    <= 1'b0;
      phase_q    <= 1'b0;
      press_q    <= '0;
      rel_q      <= '0;
      rep_pend_q <= 1'b0;
      rep_pkey_q <= '0;
      ovf_q      <= 1'b0;
      mem_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      fcnt_q     <= '0;
    end else begin
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      keys_q     <= keys_d;
      rep_key_q  <= rep_key_d;
      rep_cnt_q  <= rep_cnt_d;
      armed_q    <= armed_d;
      phase_q    <= phase_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      rep_pend_q <= rep_pend_d;
      rep_pkey_q <= rep_pkey_d;
      ovf_q      <= ovf_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      fcnt_q     <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_tm1638_key_events.sv
// Directed bench for tm1638_key_events.
// TICK_DIV=4, DEBOUNCE=3, REPEAT_DELAY=5, REPEAT_RATE=2.
module tb_tm1638_key_events;

  logic       mclk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] push_buttons = 8'h00;
  logic [7:0] keys_state;
  logic       event_valid;
  logic [4:0] event_code;
  logic       event_ready = 1'b0;
  logic       overflow;

  int total = 0;
  int bad = 0;
  int cycn = 0;
  logic [4:0] lcode[$];
  int         lcyc[$];
  logic [4:0] expq[$];

  tm1638_key_events #(
    .TICK_DIV(4), .DEBOUNCE(3), .REPEAT_DELAY(5), .REPEAT_RATE(2)
  ) dut (
    .mclk(mclk), .rst(rst), .push_buttons(push_buttons),
    .keys_state(keys_state), .event_valid(event_valid),
    .event_code(event_code), .event_ready(event_ready),
    .overflow(overflow)
  );

  always #5 mclk = ~mclk;

  // Log every accepted event with its cycle number
  always @(posedge mclk) begin
    cycn <= cycn + 1;
    if (!rst && event_valid && event_ready) begin
      lcode.push_back(event_code);
      lcyc.push_back(cycn);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic ticks(input int n);
    cyc(4 * n);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_n"}, lcode.size(), expq.size());
    for (int i = 0; i < lcode.size() && i < expq.size(); i++)
      chk($sformatf("%s_%0d", tag, i), lcode[i], expq[i]);
    lcode.delete();
    lcyc.delete();
  endtask

  initial begin
    // reset values
    push_buttons = 8'hFF;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_keys", keys_state, 8'h00);
      chk("rst_valid", event_valid, 1'b0);
      chk("rst_ovf", overflow, 1'b0);
      chk("rst_code", event_code, 5'd0);
      cyc(1);
    end
    push_buttons = 8'h00;
    cyc(1);
    rst = 1'b0;

    // debounce threshold on key 2
    push_buttons = 8'h04;
    ticks(2);
    chk("deb_before", keys_state, 8'h00);
    ticks(1);
    chk("deb_keys", keys_state, 8'h04);
    chk("deb_lat1", event_valid, 1'b0);
    cyc(1);
    chk("deb_lat2", event_valid, 1'b1);
    chk("deb_code", event_code, 5'b01_010);
    event_ready = 1'b1;
    cyc(1);
    event_ready = 1'b0;
    chk("deb_pop", event_valid, 1'b0);
    lcode.delete();
    lcyc.delete();
    event_ready = 1'b1;
    push_buttons = 8'h00;
    ticks(3);
    cyc(4);
    expq = '{5'h12};
    check_log("rel2");

    // two-tick glitch on key 3
    push_buttons = 8'h08;
    ticks(2);
    push_buttons = 8'h00;
    ticks(3);
    cyc(4);
    chk("glitch_keys", keys_state, 8'h00);
    expq = {};
    check_log("glitch");

    // auto-repeat on key 5
    push_buttons = 8'h20;
    ticks(12);
    push_buttons = 8'h00;
    ticks(3);
    cyc(4);
    ticks(6);
    if (lcyc.size() >= 4) begin
      chk("rep_delay", lcyc[1] - lcyc[0], 20);
      chk("rep_rate1", lcyc[2] - lcyc[1], 8);
      chk("rep_rate2", lcyc[3] - lcyc[2], 8);
    end
    expq = '{5'h0D, 5'h1D, 5'h1D, 5'h1D, 5'h1D, 5'h15};
    check_log("rep");

    // simultaneous presses of keys 0, 3, 7
    push_buttons = 8'h89;
    ticks(3);
    cyc(4);
    chk("sim_repkey", dut.rep_key_q, 3'd7);
    if (lcyc.size() >= 3) begin
      chk("sim_gap1", lcyc[1] - lcyc[0], 1);
      chk("sim_gap2", lcyc[2] - lcyc[1], 1);
    end
    expq = '{5'h08, 5'h0B, 5'h0F};
    check_log("sim");
    push_buttons = 8'h00;
    ticks(3);
    cyc(4);
    expq = '{5'h10, 5'h13, 5'h17};
    check_log("simrel");

    // back-pressure and overflow
    event_ready = 1'b0;
    push_buttons = 8'h0F;
    ticks(3);
    cyc(4);
    chk("bp_full", dut.fcnt_q, 3'd4);
    push_buttons = 8'h1F;
    ticks(3);
    cyc(2);
    chk("bp_keys", keys_state, 8'h1F);
    chk("bp_ovf0", overflow, 1'b0);
    chk("bp_head", event_code, 5'h08);
    push_buttons = 8'h0F;
    ticks(3);
    chk("bp_ovf1", overflow, 1'b0);
    push_buttons = 8'h1F;
    ticks(3);
    cyc(1);
    chk("bp_ovf2", overflow, 1'b1);
    event_ready = 1'b1;
    push_buttons = 8'h00;
    ticks(3);
    cyc(8);
    chk("bp_ovf3", overflow, 1'b1);
    expq = '{5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h14,
             5'h10, 5'h11, 5'h12, 5'h13, 5'h14};
    check_log("bp");

    // reset mid-operation
    event_ready = 1'b0;
    push_buttons = 8'h03;
    ticks(3);
    cyc(4);
    push_buttons = 8'h0B;
    ticks(2);
    chk("mid_fcnt", dut.fcnt_q, 3'd2);
    chk("mid_cnt3", dut.cnt_q[3], 2'd2);
    rst = 1'b1;
    cyc(1);
    chk("mid_valid", event_valid, 1'b0);
    chk("mid_keys", keys_state, 8'h00);
    chk("mid_ovf", overflow, 1'b0);
    rst = 1'b0;
    ticks(2);
    chk("mid_re2", keys_state, 8'h00);
    ticks(1);
    chk("mid_re3", keys_state, 8'h0B);
    cyc(1);
    chk("mid_head", event_code, 5'h08);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
